uart_frame_decoder: RTL and testbench

- Consumes the byte stream from the UART receiver, one byte per single-cycle valid strobe, and extracts framed command packets.
- Frame format: SYNC, CMD, LEN, LEN payload bytes, CHK.
- CHK is the mod-256 sum of CMD, LEN and all payload bytes.
- Good frames present CMD/LEN on held outputs and the payload in an internal buffer with a registered read port. Malformed or stalled frames raise single-cycle error pulses.

---
 rtl/uart_frame_decoder.sv | 159 +++++++++++++++
 tb/tb_uart_frame_decoder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_frame_decoder.sv
// Framed command decoder: SYNC, CMD, LEN, payload, CHK (mod-256 sum of CMD, LEN, payload).
// Good frames latch CMD/LEN and leave the payload in a buffer with a registered read port.
module uart_frame_decoder #(
    parameter int unsigned CLK          = 50_000_000,
    parameter int unsigned BAUD_RATE    = 115200,
    parameter int unsigned MAX_LEN      = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = (CLK / BAUD_RATE) * 10 * 4
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    input  logic [7:0] i_Rd_Addr,
    output logic [7:0] o_Rd_Data,
    output logic       o_Frame_Valid,
    output logic [7:0] o_Cmd,
    output logic [7:0] o_Len,
    output logic       o_Err_Chk,
    output logic       o_Err_Len,
    output logic       o_Err_Timeout,
    output logic       o_Busy
);

    localparam int unsigned AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [8:0]  MAX_LEN_W = 9'(MAX_LEN);
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CLKS) - 32'd1;

    typedef enum logic [2:0] {StIdle, StCmd, StLen, StPayload, StCheck} state_t;

    state_t      r_state, w_state_n;
    logic [7:0]  r_sum, w_sum_n;
    logic [7:0]  r_cmd_stage, w_cmd_stage_n;
    logic [7:0]  r_len_stage, w_len_stage_n;
    logic [7:0]  r_idx, w_idx_n;
    logic [31:0] r_timer, w_timer_n;
    logic [7:0]  r_cmd, w_cmd_n;
    logic [7:0]  r_len, w_len_n;
    logic        r_valid, w_valid_n;
    logic        r_err_chk, w_err_chk_n;
    logic        r_err_len, w_err_len_n;
    logic        r_err_to, w_err_to_n;
    logic        w_wr_en;
    logic [7:0]  r_buf [MAX_LEN];
    logic [7:0]  r_rd_data;
    logic [AW-1:0] w_wr_idx, w_rd_idx;

    assign w_wr_idx = r_idx[AW-1:0];
    assign w_rd_idx = i_Rd_Addr[AW-1:0];

    always_comb begin
        w_state_n     = r_state;
        w_sum_n       = r_sum;
        w_cmd_stage_n = r_cmd_stage;
        w_len_stage_n = r_len_stage;
        w_idx_n       = r_idx;
        w_cmd_n       = r_cmd;
        w_len_n       = r_len;
        w_valid_n     = 1'b0;
        w_err_chk_n   = 1'b0;
        w_err_len_n   = 1'b0;
        w_err_to_n    = 1'b0;
        w_wr_en       = 1'b0;
        w_timer_n     = (r_state == StIdle || i_RX_DV) ? 32'd0 : r_timer + 32'd1;

        if (i_RX_DV) begin
            // A byte in the expiry cycle takes precedence over the timeout.
            unique case (r_state)
                StIdle: begin
                    if (i_RX_Byte == SYNC_BYTE) w_state_n = StCmd;
                end
                StCmd: begin
                    w_cmd_stage_n = i_RX_Byte;
                    w_sum_n       = i_RX_Byte;
                    w_state_n     = StLen;
                end
                StLen: begin
                    if ({1'b0, i_RX_Byte} > MAX_LEN_W) begin
                        w_err_len_n = 1'b1;
                        w_state_n   = StIdle;
                    end else begin
                        w_len_stage_n = i_RX_Byte;
                        w_sum_n       = r_sum + i_RX_Byte;
                        w_idx_n       = 8'd0;
                        w_state_n     = (i_RX_Byte == 8'd0) ? StCheck : StPayload;
                    end
                end
                StPayload: begin
                    w_wr_en = 1'b1;
                    w_sum_n = r_sum + i_RX_Byte;
                    w_idx_n = r_idx + 8'd1;
                    if (r_idx == r_len_stage - 8'd1) w_state_n = StCheck;
                end
                StCheck: begin
                    if (i_RX_Byte == r_sum) begin
                        w_valid_n = 1'b1;
                        w_cmd_n   = r_cmd_stage;
                        w_len_n   = r_len_stage;
                    end else begin
                        w_err_chk_n = 1'b1;
                    end
                    w_state_n = StIdle;
                end
                default: w_state_n = StIdle;
            endcase
        end else if (r_state != StIdle && r_timer == TO_LAST) begin
            w_err_to_n = 1'b1;
            w_state_n  = StIdle;
            w_timer_n  = 32'd0;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state     <= StIdle;
            r_sum       <= 8'd0;
            r_cmd_stage <= 8'd0;
            r_len_stage <= 8'd0;
            r_idx       <= 8'd0;
            r_timer     <= 32'd0;
            r_cmd       <= 8'd0;
            r_len       <= 8'd0;
            r_valid     <= 1'b0;
            r_err_chk   <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_to    <= 1'b0;
            r_rd_data   <= 8'd0;
        end else begin
            r_state     <= w_state_n;
            r_sum       <= w_sum_n;
            r_cmd_stage <= w_cmd_stage_n;
            r_len_stage <= w_len_stage_n;
            r_idx       <= w_idx_n;
            r_timer     <= w_timer_n;
            r_cmd       <= w_cmd_n;
            r_len       <= w_len_n;
            r_valid     <= w_valid_n;
            r_err_chk   <= w_err_chk_n;
            r_err_len   <= w_err_len_n;
            r_err_to    <= w_err_to_n;
            r_rd_data   <= ({1'b0, i_Rd_Addr} >= MAX_LEN_W) ? 8'd0 : r_buf[w_rd_idx];
        end
    end

    // Payload storage is deliberately not reset.
    always_ff @(posedge i_Clock) begin
        if (w_wr_en) r_buf[w_wr_idx] <= i_RX_Byte;
    end

    assign o_Rd_Data     = r_rd_data;
    assign o_Frame_Valid = r_valid;
    assign o_Cmd         = r_cmd;
    assign o_Len         = r_len;
    assign o_Err_Chk     = r_err_chk;
    assign o_Err_Len     = r_err_len;
    assign o_Err_Timeout = r_err_to;
    assign o_Busy        = (r_state != StIdle);

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder: good/bad frames, length error, timeout, wrap, reset.
module tb_uart_frame_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       dv;
    logic [7:0] rx_byte;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_valid;
    logic [7:0] cmd;
    logic [7:0] len;
    logic       err_chk;
    logic       err_len;
    logic       err_to;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_frame_decoder #(
        .MAX_LEN     (16),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CLKS(50)
    ) dut (
        .i_Clock      (clk),
        .i_Reset      (rst),
        .i_RX_DV      (dv),
        .i_RX_Byte    (rx_byte),
        .i_Rd_Addr    (rd_addr),
        .o_Rd_Data    (rd_data),
        .o_Frame_Valid(frame_valid),
        .o_Cmd        (cmd),
        .o_Len        (len),
        .o_Err_Chk    (err_chk),
        .o_Err_Len    (err_len),
        .o_Err_Timeout(err_to),
        .o_Busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one strobe and returns at the next negedge.
    task automatic send(input logic [7:0] b);
        dv      = 1'b1;
        rx_byte = b;
        @(negedge clk);
        dv      = 1'b0;
    endtask

    task automatic flags(input string tag, input logic v, input logic ec, input logic el,
                         input logic et);
        check({tag, ".valid"}, {31'd0, frame_valid}, {31'd0, v});
        check({tag, ".err_chk"}, {31'd0, err_chk}, {31'd0, ec});
        check({tag, ".err_len"}, {31'd0, err_len}, {31'd0, el});
        check({tag, ".err_to"}, {31'd0, err_to}, {31'd0, et});
    endtask

    task automatic read(input string tag, input logic [7:0] a, input logic [7:0] exp);
        rd_addr = a;
        @(negedge clk);
        check(tag, {24'd0, rd_data}, {24'd0, exp});
    endtask

    initial begin
        rst = 1'b1; dv = 1'b0; rx_byte = 8'h00; rd_addr = 8'h00;
        repeat (3) @(negedge clk);
        flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.cmd", {24'd0, cmd}, 32'd0);
        check("reset.len", {24'd0, len}, 32'd0);
        check("reset.rd", {24'd0, rd_data}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Good frame
        send(8'hA5); send(8'h10); send(8'h03);
        check("good.busy", {31'd0, busy}, 32'd1);
        send(8'h11); send(8'h22); send(8'h33);
        flags("good.pre", 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h79);
        flags("good", 1'b1, 1'b0, 1'b0, 1'b0);
        check("good.cmd", {24'd0, cmd}, 32'h10);
        check("good.len", {24'd0, len}, 32'h03);
        check("good.busy_end", {31'd0, busy}, 32'd0);
        @(negedge clk);
        flags("good.post", 1'b0, 1'b0, 1'b0, 1'b0);
        read("good.rd0", 8'd0, 8'h11);
        read("good.rd1", 8'd1, 8'h22);
        read("good.rd2", 8'd2, 8'h33);

        // Checksum error keeps previous CMD/LEN
        send(8'hA5); send(8'h44); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        send(8'h78);
        flags("chk", 1'b0, 1'b1, 1'b0, 1'b0);
        check("chk.cmd", {24'd0, cmd}, 32'h10);
        check("chk.len", {24'd0, len}, 32'h03);
        @(negedge clk);
        flags("chk.post", 1'b0, 1'b0, 1'b0, 1'b0);

        // Length error, idle garbage, then zero-length frame
        send(8'hA5); send(8'h20);
        send(8'h11);
        flags("len", 1'b0, 1'b0, 1'b1, 1'b0);
        check("len.busy", {31'd0, busy}, 32'd0);
        send(8'h00);
        flags("len.post", 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h12);
        check("idle.busy", {31'd0, busy}, 32'd0);
        send(8'hA5); send(8'h7F); send(8'h00);
        send(8'h7F);
        flags("zero", 1'b1, 1'b0, 1'b0, 1'b0);
        check("zero.cmd", {24'd0, cmd}, 32'h7F);
        check("zero.len", {24'd0, len}, 32'h00);

        // Timeout: fires exactly 50 cycles after the last strobe
        send(8'hA5); send(8'h10); send(8'h02); send(8'hAA);
        for (int i = 1; i < 50; i++) begin
            @(negedge clk);
            check("to.wait", {31'd0, err_to}, 32'd0);
        end
        @(negedge clk);
        flags("to", 1'b0, 1'b0, 1'b0, 1'b1);
        check("to.busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("to.post", {31'd0, err_to}, 32'd0);

        // Byte in the expiry cycle wins
        send(8'hA5); send(8'h10); send(8'h02); send(8'hAA);
        repeat (49) @(negedge clk);
        send(8'hBB);
        flags("late", 1'b0, 1'b0, 1'b0, 1'b0);
        check("late.busy", {31'd0, busy}, 32'd1);
        send(8'h77);
        flags("late.frame", 1'b1, 1'b0, 1'b0, 1'b0);
        check("late.cmd", {24'd0, cmd}, 32'h10);
        check("late.len", {24'd0, len}, 32'h02);

        // Full-length payload with wrapping sum
        send(8'hA5); send(8'h01); send(8'h10);
        for (int i = 0; i < 16; i++) send(8'hFF);
        send(8'h01);
        flags("wrap", 1'b1, 1'b0, 1'b0, 1'b0);
        check("wrap.len", {24'd0, len}, 32'h10);
        read("wrap.rd15", 8'd15, 8'hFF);
        read("wrap.rd16", 8'd16, 8'h00);
        read("wrap.rd200", 8'd200, 8'h00);

        // Reset mid-frame
        send(8'hA5); send(8'h10); send(8'h03); send(8'h11); send(8'h22);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.cmd", {24'd0, cmd}, 32'd0);
        check("rst.len", {24'd0, len}, 32'd0);
        @(negedge clk);
        flags("rst.post", 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'hA5); send(8'h10); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        send(8'h79);
        flags("rst.good", 1'b1, 1'b0, 1'b0, 1'b0);
        check("rst.good.cmd", {24'd0, cmd}, 32'h10);
        check("rst.good.len", {24'd0, len}, 32'h03);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
